// File: rtl/gt_share_arb.sv
// gt_share_arb: round-robin arbiter that time-shares a single 4-bit
// unsigned greater-than comparator among NREQ requesters. A granted
// request is registered, compared in the next cycle, and its result is
// presented on one response channel with backpressure.
// Optional macro GT_SHARE_ARB_EQ_EN adds the rsp_aeqb equality output.

module gt_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic       o_gt
);
    assign o_gt = (i_a > i_b);
endmodule

module gt_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
`ifdef GT_SHARE_ARB_EQ_EN
    output logic              rsp_aeqb,
`endif
    output logic              rsp_agtb
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_ptr;
    logic [3:0]       r_a_q;
    logic [3:0]       r_b_q;
    logic [IDW-1:0]   r_id_q;
    logic             r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic             r_rsp_agtb;
`ifdef GT_SHARE_ARB_EQ_EN
    logic             r_rsp_aeqb;
`endif

    logic [IDW:0]     w_sum;
    logic [IDW-1:0]   w_win;
    logic             w_found;
    logic [NREQ-1:0]  w_req_ready;
    logic             w_accept;
    logic             w_done;
    logic             w_gt;
    logic [IDW+1:0]   w_base;

    // Round-robin search: first valid requester at or after r_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_sum = w_sum - (IDW+1)'(NREQ);
            end
            if (!w_found && req_valid[w_sum[IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[IDW-1:0];
            end
        end
    end

    // Next-state and handshake decode; grants are suppressed while in reset.
    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found && rst_n) begin
                    w_req_ready = NREQ'(1) << w_win;
                    w_accept    = 1'b1;
                    w_state_nxt = COMPARE;
                end
            end
            COMPARE: begin
                w_state_nxt = RESPOND;
            end
            RESPOND: begin
                if (rsp_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_base = {w_win, 2'b00};

    gt_4bit u_gt (
        .i_a  (r_a_q),
        .i_b  (r_b_q),
        .o_gt (w_gt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture on grant and round-robin pointer advance on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_q  <= '0;
            r_b_q  <= '0;
            r_id_q <= '0;
            r_ptr  <= '0;
        end else begin
            if (w_accept) begin
                r_a_q  <= req_a[w_base +: 4];
                r_b_q  <= req_b[w_base +: 4];
                r_id_q <= w_win;
            end
            if (w_done) begin
                r_ptr <= (r_id_q == IDW'(NREQ-1)) ? '0 : r_id_q + 1'b1;
            end
        end
    end

    // Response registers: loaded in COMPARE, held through RESPOND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_agtb  <= 1'b0;
`ifdef GT_SHARE_ARB_EQ_EN
            r_rsp_aeqb  <= 1'b0;
`endif
        end else begin
            if (r_state == COMPARE) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_id_q;
                r_rsp_agtb  <= w_gt;
`ifdef GT_SHARE_ARB_EQ_EN
                r_rsp_aeqb  <= (r_a_q == r_b_q);
`endif
            end else if (w_done) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_agtb  = r_rsp_agtb;
`ifdef GT_SHARE_ARB_EQ_EN
    assign rsp_aeqb  = r_rsp_aeqb;
`endif

endmodule

// File: tb/tb_gt_share_arb.sv
// Directed bench for gt_share_arb (NREQ=4, IDW=2) with hand-computed
// expected grants and comparator results.

module tb_gt_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_agtb;
`ifdef GT_SHARE_ARB_EQ_EN
    logic              rsp_aeqb;
`endif

    logic [3:0] a_v [NREQ];
    logic [3:0] b_v [NREQ];

    int n_chk;
    int n_bad;

    assign req_a = {a_v[3], a_v[2], a_v[1], a_v[0]};
    assign req_b = {b_v[3], b_v[2], b_v[1], b_v[0]};

    gt_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
`ifdef GT_SHARE_ARB_EQ_EN
        .rsp_aeqb  (rsp_aeqb),
`endif
        .rsp_agtb  (rsp_agtb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from IDLE: grant, compare, respond with rsp_ready=1.
    task automatic xact(input logic [NREQ-1:0] vld, input int exp_id, input logic exp_gt);
        req_valid = vld;
        #1;
        chk("grant", 32'(req_ready), 32'(1 << exp_id));
        tick();
        chk("cmp_ready", 32'(req_ready), 32'd0);
        chk("cmp_vld", 32'(rsp_valid), 32'd0);
        tick();
        chk("rsp_vld", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(exp_id));
        chk("rsp_gt", 32'(rsp_agtb), 32'(exp_gt));
        chk("rsp_ready0", 32'(req_ready), 32'd0);
`ifdef GT_SHARE_ARB_EQ_EN
        chk("rsp_eq", 32'(rsp_aeqb), 32'(a_v[exp_id] == b_v[exp_id]));
`endif
        tick();
        chk("done_vld", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        n_chk     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        a_v[0] = 4'd9;  b_v[0] = 4'd5;
        a_v[1] = 4'd3;  b_v[1] = 4'd8;
        a_v[2] = 4'd7;  b_v[2] = 4'd7;
        a_v[3] = 4'd12; b_v[3] = 4'd2;

        // Reset values
        #12;
        chk("rst_vld", 32'(rsp_valid), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_gt", 32'(rsp_agtb), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        tick();
        rst_n = 1'b1;

        // Single requester, 9 > 5 then 5 > 9
        xact(4'b0001, 0, 1'b1);
        a_v[0] = 4'd5; b_v[0] = 4'd9;
        xact(4'b0001, 0, 1'b0);
        a_v[0] = 4'd9; b_v[0] = 4'd5;

        // Fresh pointer, all four continuously valid: 0,1,2,3,0
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        xact(4'b1111, 0, 1'b1);
        xact(4'b1111, 1, 1'b0);
        xact(4'b1111, 2, 1'b0);
        xact(4'b1111, 3, 1'b1);
        xact(4'b1111, 0, 1'b1);

        // Pointer now 1; serve 1 alone to move it to 2, then 1 and 3 contend
        xact(4'b0010, 1, 1'b0);
        xact(4'b1010, 3, 1'b1);
        xact(4'b1010, 1, 1'b0);
        xact(4'b1010, 3, 1'b1);

        // Equal operands on requester 2 (pointer 0 -> 2 wins alone)
        xact(4'b0100, 2, 1'b0);

        // Backpressure: pointer is 3, only requester 0 valid
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        #1;
        chk("bp_grant", 32'(req_ready), 32'd1);
        tick();
        req_valid = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", 32'(rsp_valid), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd0);
            chk("bp_gt", 32'(rsp_agtb), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
            tick();
        end
        chk("bp_hold_vld", 32'(rsp_valid), 32'd1);
        chk("bp_hold_ready", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        tick();
        chk("bp_done", 32'(rsp_valid), 32'd0);
        chk("bp_next_grant", 32'(req_ready), 32'b0010);
        req_valid = 4'b0000;
        #1;
        chk("withdraw", 32'(req_ready), 32'd0);

        // Reset during COMPARE: pointer 1, requester 1 granted then aborted
        req_valid = 4'b1111;
        #1;
        chk("ab_grant", 32'(req_ready), 32'b0010);
        tick();
        chk("ab_cmp_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("ab_vld", 32'(rsp_valid), 32'd0);
        chk("ab_id", 32'(rsp_id), 32'd0);
        chk("ab_gt", 32'(rsp_agtb), 32'd0);
        chk("ab_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        chk("ab_vld2", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ab_fresh", 32'(req_ready), 32'b0001);
        tick();
        tick();
        chk("ab_rsp_id", 32'(rsp_id), 32'd0);
        chk("ab_rsp_vld", 32'(rsp_valid), 32'd1);
        tick();
        chk("ab_done", 32'(rsp_valid), 32'd0);
        xact(4'b1111, 1, 1'b0);

        // Exhaustive operand sweep on requester 2
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                a_v[2] = 4'(ai);
                b_v[2] = 4'(bi);
                xact(4'b0100, 2, (ai > bi));
            end
        end
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
